// File: rtl/log_mac_pkg.sv
// Shared definitions for the log-domain MAC accumulation path.
// Holds the accumulator FSM state encoding and the accumulator guard-bit count.
package log_mac_pkg;

  localparam int ACC_GUARD = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_add_signed.sv
// Combinational W-bit two's-complement adder with signed-overflow detect.
// Define ACC_SATURATE_EN to clamp the sum on overflow; otherwise it wraps.
module sat_add_signed #(
  parameter int W = 40
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] raw;

  // NOTE: combinational blocks use blocking '=' so later lines see the fresh value of raw.
  always_comb begin
    raw = a + b;
    ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
`ifdef ACC_SATURATE_EN
    if (ovf) begin
      sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sum = raw;
    end
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/log_mac_accumulator.sv
// Accumulates signed antilog product terms into a dot product, one term per handshake.
// Define ACC_SATURATE_EN for clamping accumulation with a reported overflow flag.
module log_mac_accumulator
  import log_mac_pkg::*;
#(
  parameter int DataIN_width = 16,
  parameter int ACC_width    = 2*DataIN_width + ACC_GUARD,
  parameter int LEN_width    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LEN_width-1:0]      cfg_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*DataIN_width-1:0] in_data,
  input  logic                      in_sign,
  input  logic                      in_zero,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_width-1:0]      out_data,
  output logic                      out_ovf
);

  state_e               state_q, state_d;
  logic [ACC_width-1:0] acc_q, acc_d;
  logic [LEN_width:0]   cnt_q, cnt_d;
  logic [LEN_width-1:0] len_q, len_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_width-1:0] term;
  logic [ACC_width-1:0] add_sum;
  logic                 add_ovf;
  logic                 accept;

  always_comb begin
    term = '0;
    if (!in_zero) begin
      term = ACC_width'(in_data);
      if (in_sign) term = '0 - term;
    end
  end

  sat_add_signed #(.W(ACC_width)) u_add (
    .a   (acc_q),
    .b   (term),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // NOTE: every signal gets a default first so no branch can leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    in_ready = (state_q != ST_HOLD);
    accept   = in_valid && in_ready;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          len_d   = (cfg_len == '0) ? LEN_width'(1) : cfg_len;
          acc_d   = term;
          cnt_d   = (LEN_width+1)'(1);
          ovf_d   = 1'b0;
          state_d = (len_d == LEN_width'(1)) ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_q + (LEN_width+1)'(1);
          if (cnt_d == {1'b0, len_q}) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = out_valid ? acc_q : '0;

`ifdef ACC_SATURATE_EN
  assign out_ovf = out_valid & ovf_q;
`else
  // The wrapped result is the intended output here, so the flag is tracked but not reported.
  assign out_ovf = out_valid & ovf_q & 1'b0;
`endif

endmodule

// File: tb/tb_log_mac_accumulator.sv
// Self-checking bench for log_mac_accumulator: directed and random frames against an arithmetic model.
// Follows the ACC_SATURATE_EN build setting when forming expected results.
module tb_log_mac_accumulator;

  localparam int DW  = 16;
  localparam int ACC = 2*DW + 8;
  localparam int LW  = 8;
  localparam longint MAXV = (longint'(1) << (ACC-1)) - 1;
  localparam longint MINV = -(longint'(1) << (ACC-1));
  localparam longint MODV = longint'(1) << ACC;

  logic              clk = 1'b0;
  logic              rst;
  logic [LW-1:0]     cfg_len;
  logic              in_valid;
  logic              in_ready;
  logic [2*DW-1:0]   in_data;
  logic              in_sign;
  logic              in_zero;
  logic              out_valid;
  logic              out_ready;
  logic [ACC-1:0]    out_data;
  logic              out_ovf;

  int checks = 0;
  int fails  = 0;

  logic [2*DW-1:0] q_d[$];
  bit              q_s[$];
  bit              q_z[$];

  always #5 clk = ~clk;

  log_mac_accumulator #(.DataIN_width(DW), .ACC_width(ACC), .LEN_width(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sign   (in_sign),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_term(input logic [2*DW-1:0] d, input bit s, input bit z);
    q_d.push_back(d);
    q_s.push_back(s);
    q_z.push_back(z);
  endtask

  // Called at a negedge; returns at the negedge after the term was accepted.
  task automatic push(input logic [2*DW-1:0] d, input bit s, input bit z);
    int budget = 100;
    in_valid = 1'b1;
    in_data  = d;
    in_sign  = s;
    in_zero  = z;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("in_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_sign  = 1'($urandom);
    in_zero  = 1'($urandom);
  endtask

  // Plays the queued terms as one frame, then checks result, stalls, and handshakes.
  task automatic run_frame(input int cfg, input int gap_max, input int bp, input string tag);
    int       n = (cfg == 0) ? 1 : cfg;
    longint   acc = 0;
    longint   v;
    bit       ovf = 1'b0;
    logic [ACC-1:0] exp_data;
    logic     exp_ovf;
    for (int i = 0; i < n; i++) begin
      v = q_z[i] ? 0 : (q_s[i] ? -longint'({32'b0, q_d[i]}) : longint'({32'b0, q_d[i]}));
      if (i == 0) begin
        acc = v;
      end else begin
        acc += v;
        if (acc > MAXV) begin
          ovf = 1'b1;
`ifdef ACC_SATURATE_EN
          acc = MAXV;
`else
          acc -= MODV;
`endif
        end else if (acc < MINV) begin
          ovf = 1'b1;
`ifdef ACC_SATURATE_EN
          acc = MINV;
`else
          acc += MODV;
`endif
        end
      end
    end
    exp_data = acc[ACC-1:0];
`ifdef ACC_SATURATE_EN
    exp_ovf = ovf;
`else
    exp_ovf = 1'b0;
`endif

    cfg_len = LW'(cfg);
    for (int i = 0; i < n; i++) begin
      if (i > 0) cfg_len = LW'($urandom);
      check({tag, "_early_valid"}, 64'(out_valid), 64'd0);
      push(q_d[i], q_s[i], q_z[i]);
      if (i < n-1) repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_in_ready_hold"}, 64'(in_ready), 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'(exp_data));
    check({tag, "_out_ovf"}, 64'(out_ovf), 64'(exp_ovf));
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_stall_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_stall_data"}, 64'(out_data), 64'(exp_data));
      check({tag, "_stall_ovf"}, 64'(out_ovf), 64'(exp_ovf));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_post_ready"}, 64'(in_ready), 64'd1);
    q_d.delete();
    q_s.delete();
    q_z.delete();
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    cfg_len   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sign   = 1'b0;
    in_zero   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_out_ovf", 64'(out_ovf), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    add_term(32'd100, 1'b0, 1'b0);
    add_term(32'd200, 1'b0, 1'b0);
    add_term(32'd50,  1'b1, 1'b0);
    add_term(32'd7,   1'b0, 1'b0);
    run_frame(4, 0, 0, "basic");

    add_term(32'd5,   1'b0, 1'b0);
    add_term(32'd999, 1'b0, 1'b1);
    add_term(32'd6,   1'b0, 1'b0);
    run_frame(3, 0, 0, "zero_flag");

    add_term(32'd9,  1'b1, 1'b0);
    add_term(32'd30, 1'b0, 1'b0);
    run_frame(2, 0, 5, "backpressure");

    add_term(32'd42, 1'b0, 1'b0);
    run_frame(0, 0, 1, "len0");

    for (int i = 0; i < 255; i++) add_term(32'd1, 1'b0, 1'b0);
    run_frame(255, 0, 0, "len255");

    for (int i = 0; i < 255; i++) add_term(32'hFFFF_FFFF, 1'b0, 1'b0);
    run_frame(255, 0, 2, "ovf_pos");

    for (int i = 0; i < 255; i++) add_term(32'hFFFF_FFFF, 1'b1, 1'b0);
    run_frame(255, 0, 0, "ovf_neg");

    // Abandon a frame halfway with an asynchronous reset pulse.
    cfg_len = 8'd4;
    push(32'd1, 1'b0, 1'b0);
    push(32'd1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_no_result", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) add_term(32'd1, 1'b0, 1'b0);
    run_frame(4, 0, 0, "after_rst");

    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++)
        add_term($urandom, 1'($urandom), ($urandom_range(0, 7) == 0));
      run_frame((n == 1 && $urandom_range(0, 1) == 1) ? 0 : n, 2, $urandom_range(0, 3), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
